mem_stage: RTL

- Memory-access pipeline stage that sits directly downstream of the execute stage.
- Contains the EX/MEM pipeline register and issues loads and stores to the data memory through a variable-latency req/ack handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Drives the MEM/WB pipeline register and provides the ALU_RESULT_MEM / DEST_MEM / WB_EN_MEM forwarding sources used by the execute stage and the forwarding unit.

---
 rtl/mem_stage.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory-access pipeline stage that follows the execute stage. It holds the
//   EX/MEM pipeline register, issues loads and stores to the data memory over a
//   variable-latency req/ack handshake, stalls upstream while an access is
//   outstanding, and drives the MEM/WB pipeline register.
//
// Ports
//   CLK, RST                  clock, asynchronous active-high reset
//   VALID_IN .. SW_OPERAND    instruction fields from the execute stage
//   STALL                     hold the upstream stages and the PC
//   ALU_RESULT_MEM, DEST_MEM,
//   WB_EN_MEM                 EX/MEM forwarding sources
//   DMEM_REQ/WE/ADDR/WDATA    data memory request (word addressed)
//   DMEM_RDATA, DMEM_ACK      data memory response (ACK is a one-cycle strobe)
//   WB_EN_WB, DEST_WB,
//   RESULT_WB                 MEM/WB pipeline register
//   MEM_ERR                   one-cycle pulse: misaligned access or timeout
// -----------------------------------------------------------------------------
module mem_stage #(
   parameter int WORD_LEN       = 32,
   parameter int REG_ADDR_LEN   = 5,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    VALID_IN,
   input  logic                    WB_EN_IN,
   input  logic                    MEM_R_EN_IN,
   input  logic                    MEM_W_EN_IN,
   input  logic [REG_ADDR_LEN-1:0] DEST_IN,
   input  logic [WORD_LEN-1:0]     ALU_RESULT,
   input  logic [WORD_LEN-1:0]     SW_OPERAND,
   output logic                    STALL,
   output logic [WORD_LEN-1:0]     ALU_RESULT_MEM,
   output logic [REG_ADDR_LEN-1:0] DEST_MEM,
   output logic                    WB_EN_MEM,
   output logic                    DMEM_REQ,
   output logic                    DMEM_WE,
   output logic [WORD_LEN-3:0]     DMEM_ADDR,
   output logic [WORD_LEN-1:0]     DMEM_WDATA,
   input  logic [WORD_LEN-1:0]     DMEM_RDATA,
   input  logic                    DMEM_ACK,
   output logic                    WB_EN_WB,
   output logic [REG_ADDR_LEN-1:0] DEST_WB,
   output logic [WORD_LEN-1:0]     RESULT_WB,
   output logic                    MEM_ERR
);

   localparam logic [0:0]  S_IDLE   = 1'b0;
   localparam logic [0:0]  S_ACCESS = 1'b1;
   localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

   // EX/MEM register
   logic                    r_valid, r_wb_en, r_mem_r, r_mem_w;
   logic [REG_ADDR_LEN-1:0] r_dest;
   logic [WORD_LEN-1:0]     r_alu, r_wdata;

   // control
   logic [0:0]              r_state;
   logic [15:0]             r_tcnt;

   // MEM/WB register
   logic                    r_wb_en_wb, r_mem_err;
   logic [REG_ADDR_LEN-1:0] r_dest_wb;
   logic [WORD_LEN-1:0]     r_result_wb;

   logic w_is_st, w_is_ld, w_misalign, w_access, w_timeout, w_stall, w_next_mem;

   // Write wins when both enables are set.
   assign w_is_st    = r_valid & r_mem_w;
   assign w_is_ld    = r_valid & r_mem_r & ~r_mem_w;
   assign w_misalign = (w_is_st | w_is_ld) & (r_alu[1:0] != 2'b00);
   assign w_access   = (r_state == S_ACCESS);
   // ACK in the same cycle as the limit still completes the access normally.
   assign w_timeout  = w_access & ~DMEM_ACK & (r_tcnt >= TO_LIMIT);
   assign w_stall    = w_access & ~DMEM_ACK & ~w_timeout;
   // The access starts in the first cycle the instruction sits in EX/MEM,
   // so the next state is decided from the incoming fields.
   assign w_next_mem = VALID_IN & (MEM_R_EN_IN | MEM_W_EN_IN) &
                       (ALU_RESULT[1:0] == 2'b00);

   assign STALL          = w_stall;
   assign ALU_RESULT_MEM = r_alu;
   assign DEST_MEM       = r_dest;
   assign WB_EN_MEM      = r_valid & r_wb_en;
   assign DMEM_REQ       = w_access;
   assign DMEM_WE        = r_mem_w;
   assign DMEM_ADDR      = r_alu[WORD_LEN-1:2];
   assign DMEM_WDATA     = r_wdata;
   assign WB_EN_WB       = r_wb_en_wb;
   assign DEST_WB        = r_dest_wb;
   assign RESULT_WB      = r_result_wb;
   assign MEM_ERR        = r_mem_err;

   // EX/MEM register and access FSM
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_valid <= 1'b0;
         r_wb_en <= 1'b0;
         r_mem_r <= 1'b0;
         r_mem_w <= 1'b0;
         r_dest  <= '0;
         r_alu   <= '0;
         r_wdata <= '0;
         r_state <= S_IDLE;
         r_tcnt  <= '0;
      end else if (w_stall) begin
         r_tcnt <= r_tcnt + 16'd1;
      end else begin
         r_valid <= VALID_IN;
         r_wb_en <= WB_EN_IN;
         r_mem_r <= MEM_R_EN_IN;
         r_mem_w <= MEM_W_EN_IN;
         r_dest  <= DEST_IN;
         r_alu   <= ALU_RESULT;
         r_wdata <= SW_OPERAND;
         r_state <= w_next_mem ? S_ACCESS : S_IDLE;
         r_tcnt  <= '0;
      end
   end

   // MEM/WB register. Bubbles clear only the write enable; DEST/RESULT hold.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_wb_en_wb  <= 1'b0;
         r_dest_wb   <= '0;
         r_result_wb <= '0;
         r_mem_err   <= 1'b0;
      end else if (w_stall) begin
         r_wb_en_wb <= 1'b0;
         r_mem_err  <= 1'b0;
      end else begin
         r_mem_err <= w_timeout | (~w_access & w_misalign);
         if (w_access) begin
            if (DMEM_ACK && w_is_ld) begin
               r_wb_en_wb  <= r_wb_en;
               r_dest_wb   <= r_dest;
               r_result_wb <= DMEM_RDATA;
            end else begin
               r_wb_en_wb <= 1'b0;   // store completion or timeout
            end
         end else if (r_valid && !w_is_st && !w_is_ld) begin
            r_wb_en_wb  <= r_wb_en;
            r_dest_wb   <= r_dest;
            r_result_wb <= r_alu;
         end else begin
            r_wb_en_wb <= 1'b0;      // empty slot or misaligned access
         end
      end
   end

endmodule
